// File: rtl/frontend_bundle_queue.sv
// Decoupling FIFO between decode and rename, holding DEPTH decoded two-instruction bundles.
// Latency: a bundle written at edge N is visible on valid_o/bundle_o after edge N (no bypass).
// Backpressure: busy_o = full, driven only from registered count; rn_busy_i holds the head in place.
module frontend_bundle_queue #(
    parameter int DEPTH    = 4,
    parameter int BUNDLE_W = 256,
    parameter int CNT_W    = 32
) (
    input  logic                    core_clock_i,
    input  logic                    core_reset_i,
    input  logic                    core_flush_i,
    input  logic                    valid_i,
    input  logic [BUNDLE_W-1:0]     bundle_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [BUNDLE_W-1:0]     bundle_o,
    input  logic                    rn_busy_i,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic [CNT_W-1:0]        stall_cycles_o,
    output logic [CNT_W-1:0]        empty_cycles_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Bundle storage; deliberately has no reset so flush leaves stale payload behind.
    logic [BUNDLE_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_empty_cnt;

    logic w_full;
    logic w_valid;
    logic w_enq;
    logic w_deq;
    logic w_stall_evt;
    logic w_empty_evt;

    // Status flags and handshake qualifiers; flush suppresses both sides of the queue.
    always_comb begin
        w_full      = (r_count == OCC_W'(DEPTH));
        w_valid     = (r_count != '0);
        w_enq       = valid_i & ~w_full & ~core_flush_i;
        w_deq       = w_valid & ~rn_busy_i & ~core_flush_i;
        w_stall_evt = valid_i & w_full & ~core_flush_i;
        w_empty_evt = ~w_valid & ~rn_busy_i & ~core_flush_i;
    end

    // Payload write at the tail; reset takes priority over any pending enqueue.
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i && w_enq) begin
            r_mem[r_wr_ptr] <= bundle_i;
        end
    end

    // Pointer and occupancy tracking; flush rewinds everything without touching storage.
    always_ff @(posedge core_clock_i) begin
        if (!core_reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (core_flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating performance counters; survive flush, cleared only by reset.
    always_ff @(posedge core_clock_i) begin
        if (!core_reset_i) begin
            r_stall_cnt <= '0;
            r_empty_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_empty_evt && (r_empty_cnt != '1)) begin
                r_empty_cnt <= r_empty_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs come straight from registered state; head payload is a combinational read.
    always_comb begin
        busy_o         = w_full;
        valid_o        = w_valid;
        bundle_o       = r_mem[r_rd_ptr];
        occupancy_o    = r_count;
        stall_cycles_o = r_stall_cnt;
        empty_cycles_o = r_empty_cnt;
    end

endmodule

// File: doc/frontend_bundle_queue.md
Name: frontend_bundle_queue

Overview:
- Decoupling FIFO directly downstream of the frontend (pcgen → icache → decode) and upstream of rename.
- Accepts one decoded two-instruction bundle per cycle from decode and presents bundles in order to rename.
- Absorbs rename back-pressure so decode and fetch keep running for DEPTH bundles. Discards all contents on core flush.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, ≥2.
- BUNDLE_W, 256, width of the opaque packed bundle payload (ins0/ins1 decode fields, PC, BTB info).
- CNT_W, 32, width of the performance counters.

Ports:
- core_clock_i  in  1  core clock.
- core_reset_i  in  1  synchronous, active-low reset.
- core_flush_i  in  1  pipeline flush; clears queue.
- valid_i  in  1  decode presents a bundle.
- bundle_i  in  BUNDLE_W  packed bundle from decode.
- busy_o  out  1  stall to decode; bundle not accepted while high.
- valid_o  out  1  head bundle valid to rename.
- bundle_o  out  BUNDLE_W  head bundle payload.
- rn_busy_i  in  1  rename stall; head not consumed while high.
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.
- stall_cycles_o  out  CNT_W  cycles with busy_o=1 and valid_i=1.
- empty_cycles_o  out  CNT_W  cycles with valid_o=0 and rn_busy_i=0.

Behaviour:
- Storage: DEPTH×BUNDLE_W register array. Read/write pointers are $clog2(DEPTH) bits, wrapping modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Reset (core_reset_i=0 at clock edge):
  - pointers, count and both perf counters go to 0.
  - valid_o=0, busy_o=0, occupancy_o=0.
  - bundle_o is don't-care while valid_o=0.
  - Reset has priority over flush and all handshakes.
- busy_o = (count==DEPTH). It depends only on registered state; there is no combinational path from rn_busy_i or valid_i.
- valid_o = (count!=0). bundle_o = mem[rd_ptr] (registered storage, combinational read).
- Enqueue when valid_i & ~busy_o & ~core_flush_i: write bundle_i at wr_ptr, wr_ptr+1.
- Dequeue when valid_o & ~rn_busy_i & ~core_flush_i: rd_ptr+1.
- Count update: +1 on enqueue-only, −1 on dequeue-only, unchanged on both or neither.
- Latency: a bundle enqueued at edge N appears on valid_o/bundle_o in the cycle after edge N (1 cycle). There is no same-cycle bypass.
- Full: busy_o=1. valid_i is ignored even if a dequeue happens in the same cycle; the slot becomes usable next cycle.
- Empty: valid_o=0. rn_busy_i is ignored. A simultaneous enqueue still takes 1 cycle to appear.
- Enqueue and dequeue in the same cycle at any count 1..DEPTH-1: both pointers advance and count is unchanged.
- Flush: on an edge with core_flush_i=1, pointers and count go to 0. valid_i and rn_busy_i are ignored that cycle, and no entry is written or consumed.
  - The next cycle shows valid_o=0, busy_o=0.
  - Stale payload in storage is not cleared.
- Perf counters:
  - Counters saturate at all-ones and do not wrap.
  - Counters are not cleared by flush, only by reset.
  - stall_cycles_o increments on cycles where valid_i & busy_o & ~core_flush_i.
  - empty_cycles_o increments on cycles where ~valid_o & ~rn_busy_i & ~core_flush_i.
- Ordering: bundles leave in exact arrival order. No bundle is duplicated or dropped except by flush.

Test Plan:
- Reset/basic:
  - Stimulus: hold core_reset_i=0 for 2 cycles, release, then drive valid_i=1 with bundle_i=0xA5 (zero-extended) for 1 cycle, rn_busy_i=0.
  - Required: valid_o=1 with bundle_o=0xA5 exactly one cycle later. valid_o=0 the cycle after that. occupancy_o goes 0→1→0.
- Fill/full:
  - Stimulus: rn_busy_i=1, enqueue bundles 1,2,3,4,5 on consecutive cycles (DEPTH=4).
  - Required: busy_o=1 after the 4th. Bundle 5 is not accepted and decode must hold it. occupancy_o=4.
  - Then release rn_busy_i: outputs are 1,2,3,4 in order. busy_o drops the cycle after the first dequeue, and bundle 5 enqueues then.
- Simultaneous at full:
  - Stimulus: count=4, valid_i=1, rn_busy_i=0.
  - Required: dequeue only, no enqueue. occupancy_o=3 next cycle. stall_cycles_o +1.
- Wrap-around:
  - Stimulus: stream 10 bundles (0x10..0x19) with rn_busy_i toggling every cycle.
  - Required: all 10 are received in order with no loss. Pointers wrap past DEPTH correctly.
- Flush mid-operation:
  - Stimulus: count=3, assert core_flush_i with valid_i=1 and rn_busy_i=0 for one cycle.
  - Required: next cycle valid_o=0, occupancy_o=0, busy_o=0. No bundle is consumed or written that cycle. The next enqueued bundle 0x77 appears as head.
- Reset mid-operation and counters:
  - Stimulus: count=2, stall_cycles_o=5, then assert core_reset_i=0 together with core_flush_i=1.
  - Required: all state and counters read 0 the next cycle.
  - Separately, force empty_cycles_o to all-ones and check it stays at all-ones while empty.
